// File: rtl/spi_burst_sequencer.sv
`timescale 1ns/1ps
// spi_burst_sequencer: turns spi_master's single-byte start/done interface into a
// cfg_len-byte burst engine with TX/RX byte FIFOs and a single completion pulse.
//
// state       | meaning
// ------------+----------------------------------------------------------
// S_IDLE      | waiting for go; burst config latched on go
// S_ISSUE     | pop TX head into spi_tx_data, or abort on empty TX FIFO
// S_HANDSHAKE | spi_start held with stable data until spi_busy is seen
// S_WAIT_DONE | waiting for spi_done; rx byte captured into holding reg
// S_STORE     | push holding reg into RX FIFO (stalls while RX is full)
// S_FINISH    | one-cycle seq_done (+ err_underflow when aborted)

// Byte FIFO with first-word-fall-through read port; head reads as 0 when empty.
module sbs_fifo #(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [7:0]               wr_data,
   input  logic                     rd_en,
   output logic [7:0]               rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_LVL = DEPTH[AW:0];
   localparam logic [AW:0]   LVL_ONE  = 1;
   localparam logic [AW-1:0] PTR_ONE  = 1;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_wr;
   logic          do_rd;

   assign full    = (level == FULL_LVL);
   assign empty   = (level == '0);
   assign do_wr   = wr_en & ~full;
   assign do_rd   = rd_en & ~empty;
   assign rd_data = empty ? 8'h00 : mem[rd_ptr];

   // Pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
         case ({do_wr, do_rd})
            2'b10:   level <= level + LVL_ONE;
            2'b01:   level <= level - LVL_ONE;
            default: level <= level;
         endcase
      end
   end

   // Storage array; contents need no reset since empty gates the read port.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end
endmodule

module spi_burst_sequencer #(
   parameter int          TX_DEPTH        = 16,
   parameter int          RX_DEPTH        = 16,
   parameter logic [15:0] DEFAULT_CLK_DIV = 16'd4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [15:0]                 cfg_clk_div,
   input  logic [7:0]                  cfg_len,
   input  logic                        go,
   input  logic                        tx_wr_en,
   input  logic [7:0]                  tx_wr_data,
   output logic                        tx_full,
   output logic [$clog2(TX_DEPTH):0]   tx_level,
   input  logic                        rx_rd_en,
   output logic [7:0]                  rx_rd_data,
   output logic                        rx_empty,
   output logic [$clog2(RX_DEPTH):0]   rx_level,
   output logic                        seq_busy,
   output logic                        seq_done,
   output logic                        err_underflow,
   output logic                        spi_start,
   output logic [7:0]                  spi_tx_data,
   output logic [15:0]                 spi_clk_div,
   input  logic                        spi_busy,
   input  logic                        spi_done,
   input  logic [7:0]                  spi_rx_data
);
   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_HANDSHAKE, S_WAIT_DONE, S_STORE, S_FINISH
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [7:0] remain;
   logic       abort;
   logic [7:0] rx_hold;
   logic       tx_pop;
   logic       rx_push;
   logic [7:0] tx_head;
   logic       tx_empty;
   logic       rx_full;

   sbs_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (tx_wr_en),
      .wr_data (tx_wr_data),
      .rd_en   (tx_pop),
      .rd_data (tx_head),
      .full    (tx_full),
      .empty   (tx_empty),
      .level   (tx_level)
   );

   sbs_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (rx_push),
      .wr_data (rx_hold),
      .rd_en   (rx_rd_en),
      .rd_data (rx_rd_data),
      .full    (rx_full),
      .empty   (rx_empty),
      .level   (rx_level)
   );

   assign spi_start     = (state == S_HANDSHAKE);
   assign seq_busy      = (state != S_IDLE);
   assign seq_done      = (state == S_FINISH);
   assign err_underflow = (state == S_FINISH) & abort;

   // State register plus burst datapath (byte count, divider, tx/rx byte registers).
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         remain      <= 8'd0;
         abort       <= 1'b0;
         rx_hold     <= 8'd0;
         spi_tx_data <= 8'd0;
         spi_clk_div <= DEFAULT_CLK_DIV;
      end else begin
         state <= state_nxt;
         if (state == S_IDLE && go) begin
            remain      <= cfg_len;
            abort       <= 1'b0;
            spi_clk_div <= (cfg_clk_div == 16'd0) ? DEFAULT_CLK_DIV : cfg_clk_div;
         end
         if (state == S_ISSUE && tx_empty) abort <= 1'b1;
         if (tx_pop) spi_tx_data <= tx_head;
         if (state == S_WAIT_DONE && spi_done) rx_hold <= spi_rx_data;
         if (rx_push) remain <= remain - 8'd1;
      end
   end

   // Next-state and FIFO strobes.
   always_comb begin
      state_nxt = state;
      tx_pop    = 1'b0;
      rx_push   = 1'b0;
      case (state)
         S_IDLE: begin
            if (go) state_nxt = (cfg_len == 8'd0) ? S_FINISH : S_ISSUE;
         end
         S_ISSUE: begin
            if (tx_empty) begin
               state_nxt = S_FINISH;
            end else begin
               tx_pop    = 1'b1;
               state_nxt = S_HANDSHAKE;
            end
         end
         S_HANDSHAKE: begin
            if (spi_busy) state_nxt = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            if (spi_done) state_nxt = S_STORE;
         end
         S_STORE: begin
            if (!rx_full) begin
               rx_push   = 1'b1;
               state_nxt = (remain == 8'd1) ? S_FINISH : S_ISSUE;
            end
         end
         S_FINISH: state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end
endmodule
